dmem_arbiter: RTL and testbench

//   Shares the single-port synchronous data RAM between two requesters:

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_arb_pick.sv | 30 +++
 rtl/dmem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/dmem_arbiter_arb_pick.sv
// Combinational winner select for simultaneous requests.
// ARB_ROUND_ROBIN_EN: ties go to the port that did not own the last access; otherwise the loader wins.
module arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_i,
`endif
  output logic winner_o
);

  // Pick a winner; a lone requester always wins.
  always_comb begin
    winner_o = P_CPU;
    if (req0_i && req1_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner_o = other_port(last_i);
`else
      winner_o = P_LDR;
`endif
    end else if (req1_i) begin
      winner_o = P_LDR;
    end else begin
      winner_o = P_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU (port 0) and the loader (port 1).
// Tie-break policy selected by ARB_ROUND_ROBIN_EN (default: loader priority).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_ack_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_ack_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                ram_en_o,
  output logic                ram_we_o,
  output logic [DATA_W/8-1:0] ram_be_o,
  output logic [ADDR_W-3:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   winner_s;
  logic   other_req_s;

  logic                sel_we_s;
  logic [DATA_W/8-1:0] sel_be_s;
  logic [ADDR_W-3:0]   sel_waddr_s;
  logic [DATA_W-1:0]   sel_wdata_s;

  // Byte-offset bits play no part in a word-aligned RAM access.
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  arb_pick u_arb_pick (
    .req0_i   (m0_req_i),
    .req1_i   (m1_req_i),
    .last_i   (last_q),
    .winner_o (winner_s)
  );

  // Owner of the most recently completed access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= P_CPU;
    end else begin
      last_q <= last_d;
    end
  end

  // Record the finishing owner on each completion.
  always_comb begin
    last_d = last_q;
    if (state_q == S_RESP) begin
      last_d = owner_q;
    end else begin
      last_d = last_q;
    end
  end
`else
  arb_pick u_arb_pick (
    .req0_i   (m0_req_i),
    .req1_i   (m1_req_i),
    .winner_o (winner_s)
  );
`endif

  // FSM state and current owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= P_CPU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign other_req_s = (owner_q == P_LDR) ? m0_req_i : m1_req_i;

  // Next state: the non-owner gets a direct handoff out of RESP.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          state_d = S_ISSUE;
          owner_d = winner_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (other_req_s) begin
          state_d = S_ISSUE;
          owner_d = other_port(owner_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = P_CPU;
      end
    endcase
  end

  // Request fields of the current owner.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_be_s    = {(DATA_W/8){1'b0}};
    sel_waddr_s = {(ADDR_W-2){1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    if (owner_q == P_LDR) begin
      sel_we_s    = m1_we_i;
      sel_be_s    = m1_be_i;
      sel_waddr_s = m1_addr_i[ADDR_W-1:2];
      sel_wdata_s = m1_wdata_i;
    end else begin
      sel_we_s    = m0_we_i;
      sel_be_s    = m0_be_i;
      sel_waddr_s = m0_addr_i[ADDR_W-1:2];
      sel_wdata_s = m0_wdata_i;
    end
  end

  // RAM strobes only in ISSUE; an all-zero byte mask degrades to a read.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = {(DATA_W/8){1'b0}};
    ram_addr_o  = {(ADDR_W-2){1'b0}};
    ram_wdata_o = {DATA_W{1'b0}};
    if (state_q == S_ISSUE) begin
      ram_en_o    = 1'b1;
      ram_we_o    = sel_we_s & (|sel_be_s);
      ram_be_o    = sel_be_s;
      ram_addr_o  = sel_waddr_s;
      ram_wdata_o = sel_wdata_s;
    end else begin
      ram_en_o    = 1'b0;
    end
  end

  // Completion pulse and read data go to the owner only.
  always_comb begin
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_rdata_o = {DATA_W{1'b0}};
    m1_rdata_o = {DATA_W{1'b0}};
    if (state_q == S_RESP) begin
      if (owner_q == P_LDR) begin
        m1_ack_o   = 1'b1;
        m1_rdata_o = ram_rdata_i;
      end else begin
        m0_ack_o   = 1'b1;
        m0_rdata_o = ram_rdata_i;
      end
    end else begin
      m0_ack_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus two random requesters
// checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_be = 4'h0, m1_be = 4'h0;
  logic [15:0] m0_addr = 16'h0, m1_addr = 16'h0;
  logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  logic [31:0] ram     [0:16383];
  logic [31:0] ref_mem [0:16383];

  int  checks = 0;
  int  failures = 0;
  int  ack_cnt0 = 0;
  int  ack_cnt1 = 0;
  bit  mon_en = 1'b0;
  int  ack_port_q[$];
  time ack_time_q[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Synchronous RAM: read data one cycle after the strobe.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram[ram_addr];
      if (ram_we) ram[ram_addr] <= merge(ram[ram_addr], ram_wdata, ram_be);
    end
  end

  // Continuous protocol checks and ack logging.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("dual_ack", {63'd0, m0_ack & m1_ack}, 64'd0);
      check_eq("ram_quiet", ram_en ? 51'd0 : {ram_we, ram_be, ram_addr, ram_wdata}, 64'd0);
      check_eq("rdata_quiet", {m0_ack ? 32'd0 : m0_rdata, m1_ack ? 32'd0 : m1_rdata}, 64'd0);
      if (m0_ack) begin ack_cnt0++; ack_port_q.push_back(0); ack_time_q.push_back($time); end
      if (m1_ack) begin ack_cnt1++; ack_port_q.push_back(1); ack_time_q.push_back($time); end
    end
  end

  task automatic set_port(input int p, input logic req, input logic we, input logic [3:0] be,
                          input logic [15:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  // One request on port p, raised just after a rising edge; lat counts falling edges up to the ack.
  task automatic access(input int p, input logic we, input logic [3:0] be, input logic [15:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output int en_cnt, output logic [50:0] cap, output time t_ack);
    bit got;
    got = 1'b0; lat = 0; en_cnt = 0; cap = 51'd0; rd = 32'h0; t_ack = 0;
    set_port(p, 1'b1, we, be, addr, wd);
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (ram_en) begin en_cnt++; cap = {ram_we, ram_be, ram_addr, ram_wdata}; end
      if ((p == 0) ? m0_ack : m1_ack) begin
        got = 1'b1;
        rd = (p == 0) ? m0_rdata : m1_rdata;
        t_ack = $time;
      end
    end
    check_eq($sformatf("ack_seen_p%0d", p), {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    set_port(p, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  task automatic agent(input int p, input int n);
    int lat, en, gap;
    logic [31:0] rd, wd;
    logic [50:0] cap;
    logic [13:0] word;
    logic [1:0]  lsb;
    logic        we;
    logic [3:0]  be;
    time         t;
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
      we   = 1'($urandom_range(0, 1));
      be   = 4'($urandom_range(0, 15));
      word = 14'($urandom_range(0, 31));
      lsb  = 2'($urandom_range(0, 3));
      wd   = $urandom();
      access(p, we, be, {word, lsb}, wd, lat, rd, en, cap, t);
      // Worst case: lose a tie, wait out the winner, then own access.
      check_eq("rand_latency", {63'd0, lat <= 5}, 64'd1);
      if (we) ref_mem[word] = merge(ref_mem[word], wd, be);
      else    check_eq("rand_rdata", rd, ref_mem[word]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat, lat0, lat1, en, en0, en1, first, start;
    logic [31:0] rd, rd0, rd1;
    logic [50:0] cap, cap0, cap1;
    time t, t0, t1;
    bit got;

    for (int i = 0; i < 16384; i++) begin
      ram[i]     = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    ram[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    // Reset with both requests asserted: everything must stay quiet.
    m0_req = 1'b1; m1_req = 1'b1; m0_be = 4'hF; m1_be = 4'hF;
    repeat (2) @(posedge clk); #1;
    check_eq("reset_ram", {ram_en, ram_we, ram_be, ram_addr, ram_wdata}, 64'd0);
    check_eq("reset_ack", {m0_ack, m1_ack}, 64'd0);
    check_eq("reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
    set_port(0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // CPU read: ack on the second edge after the request.
    access(0, 1'b0, 4'hF, 16'h0010, 32'h0, lat, rd, en, cap, t);
    check_eq("t1_latency", lat, 64'd3);
    check_eq("t1_ram_en_cycles", en, 64'd1);
    check_eq("t1_ram_addr", cap[45:32], 64'd4);
    check_eq("t1_ram_we", cap[50], 64'd0);
    check_eq("t1_rdata", rd, 64'hDEADBEEF);

    // Loader partial write.
    start = ack_cnt0;
    access(1, 1'b1, 4'b0011, 16'h0020, 32'h12345678, lat, rd, en, cap, t);
    check_eq("t2_latency", lat, 64'd3);
    check_eq("t2_ram_we", cap[50], 64'd1);
    check_eq("t2_ram_be", cap[49:46], 64'h3);
    check_eq("t2_ram_addr", cap[45:32], 64'd8);
    check_eq("t2_ram_wdata", cap[31:0], 64'h12345678);
    check_eq("t2_cpu_no_ack", ack_cnt0, start);
    ref_mem[8] = merge(ref_mem[8], 32'h12345678, 4'b0011);

    // Simultaneous requests right after a loader access.
`ifdef ARB_ROUND_ROBIN_EN
    first = 0;
`else
    first = 1;
`endif
    fork
      access(0, 1'b0, 4'hF, 16'h0010, 32'h0, lat0, rd0, en0, cap0, t0);
      access(1, 1'b0, 4'hF, 16'h0022, 32'h0, lat1, rd1, en1, cap1, t1);
    join
    check_eq("tie_winner", (t0 < t1) ? 64'd0 : 64'd1, first);
    check_eq("tie_spacing", (t0 > t1) ? (t0 - t1) : (t1 - t0), 64'd20);
    check_eq("tie_rdata0", rd0, ref_mem[4]);
    check_eq("tie_rdata1", rd1, ref_mem[8]);

    // Both held: grants must alternate, one ack every two cycles.
    start = ack_port_q.size();
    fork
      for (int i = 0; i < 3; i++) access(0, 1'b0, 4'hF, 16'h0004, 32'h0, lat0, rd0, en0, cap0, t0);
      for (int i = 0; i < 3; i++) access(1, 1'b0, 4'hF, 16'h0008, 32'h0, lat1, rd1, en1, cap1, t1);
    join
    check_eq("held_count", ack_port_q.size() - start, 64'd6);
    for (int i = start + 1; i < ack_port_q.size(); i++) begin
      check_eq("held_alternate", {63'd0, ack_port_q[i] != ack_port_q[i-1]}, 64'd1);
      check_eq("held_gap", ack_time_q[i] - ack_time_q[i-1], 64'd20);
    end

    // Write with an empty byte mask acts as a read.
    access(0, 1'b1, 4'h0, 16'h0030, 32'hFFFFFFFF, lat, rd, en, cap, t);
    check_eq("t5_latency", lat, 64'd3);
    check_eq("t5_ram_en_cycles", en, 64'd1);
    check_eq("t5_ram_we", cap[50], 64'd0);
    access(1, 1'b0, 4'hF, 16'h0030, 32'h0, lat, rd, en, cap, t);
    check_eq("t5_unchanged", rd, ref_mem[12]);
    access(0, 1'b0, 4'hF, 16'h0021, 32'h0, lat, rd, en, cap, t);
    check_eq("t2_readback", rd, ref_mem[8]);

    // Reset in the middle of an access.
    set_port(0, 1'b1, 1'b0, 4'hF, 16'h0010, 32'h0);
    @(negedge clk);
    check_eq("t6_idle", ram_en, 64'd0);
    @(posedge clk); #2;
    check_eq("t6_issue", ram_en, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_drop", ram_en, 64'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("t6_no_ack", m0_ack, 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    got = 1'b0; lat = 0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (m0_ack) begin got = 1'b1; rd = m0_rdata; end
    end
    check_eq("t6_restart_latency", lat, 64'd3);
    check_eq("t6_restart_rdata", rd, 64'hDEADBEEF);
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);

    // Random traffic from both ports.
    fork
      agent(0, 40);
      agent(1, 40);
    join

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
